mole_scheduler: RTL

Spawns, ages and retires moles across the 20 holes of the playfield. It sits between the game controller, which provides level-dependent `gen_interval` and `life_span` plus decoded hit requests, and the display and score logic, which consume the `moles` bitmap and the per-event pulses. It owns the only copy of hole occupancy.

---
 rtl/mole_if.sv | 31 +++
 rtl/mole_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mole_if.sv
// Bundle between the game controller and mole_scheduler.
// Carries level settings and hit requests in, and the occupancy bitmap and event pulses out.
interface mole_if #(
  parameter int NUM_HOLES = 20,
  parameter int CNT_W     = 32
);
  // There is no back-pressure on this bundle. hit_valid is a one-cycle strobe that is
  // sampled on every enabled edge. Every output pulse is high for exactly one cycle.
  logic                 clear;
  logic                 enable;
  logic [CNT_W-1:0]     gen_interval;
  logic [CNT_W-1:0]     life_span;
  logic                 hit_valid;
  logic [4:0]           hit_idx;
  logic [NUM_HOLES-1:0] moles;
  logic                 spawn_pulse;
  logic                 spawn_drop;
  logic                 hit_ok;
  logic                 hit_miss;
  logic [4:0]           escape_cnt;

  modport master (
    output clear, enable, gen_interval, life_span, hit_valid, hit_idx,
    input  moles, spawn_pulse, spawn_drop, hit_ok, hit_miss, escape_cnt
  );

  modport slave (
    input  clear, enable, gen_interval, life_span, hit_valid, hit_idx,
    output moles, spawn_pulse, spawn_drop, hit_ok, hit_miss, escape_cnt
  );
endinterface

// File: rtl/mole_scheduler.sv
// Owns hole occupancy: spawns moles on an LFSR-picked hole, ages them and retires them on hit or expiry.
// All outputs are registered. Nothing advances while enable is low.
module mole_scheduler #(
  parameter int          NUM_HOLES = 20,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic   clk,
  input logic   rst_n,
  mole_if.slave bus
);
  logic [NUM_HOLES-1:0] moles;
  logic [NUM_HOLES-1:0] moles_nxt;
  logic [CNT_W-1:0]     life     [NUM_HOLES];
  logic [CNT_W-1:0]     life_nxt [NUM_HOLES];
  logic [CNT_W-1:0]     ic;
  logic [CNT_W-1:0]     gi_eff;
  logic [CNT_W-1:0]     ls_eff;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_adv;
  logic [4:0]           cand;
  logic [4:0]           place_idx;
  logic [4:0]           esc_nxt;
  logic                 fire;
  logic                 found;
  logic                 hit_ok_nxt;

  function automatic logic [4:0] reduce_hole(input logic [4:0] raw);
    logic [5:0] r;
    r = {1'b0, raw};
    for (int i = 0; i < 16; i++) begin
      if (r >= 6'(NUM_HOLES)) r = r - 6'(NUM_HOLES);
    end
    return r[4:0];
  endfunction

  function automatic logic [4:0] wrap_add(input logic [4:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_HOLES) s = s - NUM_HOLES;
    return 5'(s);
  endfunction

  assign gi_eff   = (bus.gen_interval == '0) ? CNT_W'(1) : bus.gen_interval;
  assign ls_eff   = (bus.life_span == '0) ? CNT_W'(1) : bus.life_span;
  // A shrunken interval (ic already past the new limit) fires on the next enabled cycle.
  assign fire     = bus.enable && (ic >= gi_eff - CNT_W'(1));
  assign lfsr_adv = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign cand     = reduce_hole(lfsr[4:0]);
  assign bus.moles = moles;

  // The scan reads the registered bitmap, so holes freed this cycle are not candidates yet.
  always_comb begin
    found     = 1'b0;
    place_idx = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      if (!found && !moles[wrap_add(cand, i)]) begin
        found     = 1'b1;
        place_idx = wrap_add(cand, i);
      end
    end
  end

  // For each hole, a hit takes priority over expiry. The spawn target is always a free hole,
  // so it never collides with a hit or an expiry.
  always_comb begin
    moles_nxt  = moles;
    esc_nxt    = '0;
    hit_ok_nxt = 1'b0;
    for (int h = 0; h < NUM_HOLES; h++) begin
      life_nxt[h] = life[h];
      if (moles[h]) begin
        if (bus.hit_valid && (bus.hit_idx == 5'(h))) begin
          moles_nxt[h] = 1'b0;
          life_nxt[h]  = '0;
          hit_ok_nxt   = 1'b1;
        end else if (life[h] == CNT_W'(1)) begin
          moles_nxt[h] = 1'b0;
          life_nxt[h]  = '0;
          esc_nxt      = esc_nxt + 5'd1;
        end else begin
          life_nxt[h] = life[h] - CNT_W'(1);
        end
      end
    end
    if (fire && found) begin
      moles_nxt[place_idx] = 1'b1;
      life_nxt[place_idx]  = ls_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moles           <= '0;
      ic              <= '0;
      lfsr            <= LFSR_SEED;
      bus.spawn_pulse <= 1'b0;
      bus.spawn_drop  <= 1'b0;
      bus.hit_ok      <= 1'b0;
      bus.hit_miss    <= 1'b0;
      bus.escape_cnt  <= '0;
      for (int h = 0; h < NUM_HOLES; h++) life[h] <= '0;
    end else if (bus.clear) begin
      moles           <= '0;
      ic              <= '0;
      lfsr            <= LFSR_SEED;
      bus.spawn_pulse <= 1'b0;
      bus.spawn_drop  <= 1'b0;
      bus.hit_ok      <= 1'b0;
      bus.hit_miss    <= 1'b0;
      bus.escape_cnt  <= '0;
      for (int h = 0; h < NUM_HOLES; h++) life[h] <= '0;
    end else begin
      bus.spawn_pulse <= 1'b0;
      bus.spawn_drop  <= 1'b0;
      bus.hit_ok      <= 1'b0;
      bus.hit_miss    <= 1'b0;
      bus.escape_cnt  <= '0;
      if (bus.enable) begin
        ic              <= fire ? '0 : ic + CNT_W'(1);
        if (fire) lfsr  <= lfsr_adv;
        moles           <= moles_nxt;
        for (int h = 0; h < NUM_HOLES; h++) life[h] <= life_nxt[h];
        bus.spawn_pulse <= fire && found;
        bus.spawn_drop  <= fire && !found;
        bus.hit_ok      <= hit_ok_nxt;
        bus.hit_miss    <= bus.hit_valid && !hit_ok_nxt;
        bus.escape_cnt  <= esc_nxt;
      end
    end
  end
endmodule
